clock_module: RTL and testbench

//  Generates the computer clock (clk_out) that drives every flip-flop, register and counter in the 8-bit machine.

---
 rtl/clock_module.sv | 183 ++++++++++++++++++
 tb/tb_clock_module.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_module.sv
// Computer clock generator for the 8-bit machine. It produces a divided auto clock or debounced
// single-step pulses, and halt freezes it. Every output comes from a flop, so clk_out is glitch-free.
module clock_module #(
  parameter int DIV_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int STEP_HIGH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 not_reset,
  input  logic                 mode,
  input  logic                 step_btn,
  input  logic                 halt,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 clk_out,
  output logic                 not_clk_out,
  output logic                 clk_rise
);

  localparam int                   DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]      DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] STEP_LAST = DIV_WIDTH'(STEP_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {
    AUTO_LOW,
    AUTO_HIGH,
    MAN_IDLE,
    MAN_HIGH,
    MAN_WAIT_REL,
    HALTED
  } state_t;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_btn_db;
  logic [DB_W-1:0]      r_db_cnt;
  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_clk_out;
  logic                 r_not_clk_out;
  logic                 r_clk_rise;

  logic                 w_phase_done;
  logic                 w_step_done;
  logic [DIV_WIDTH-1:0] w_cnt_inc;

  // A >= compare lets a lowered div end the current phase at once instead of wrapping.
  assign w_phase_done = (r_cnt >= div);
  assign w_step_done  = (r_cnt >= STEP_LAST);
  assign w_cnt_inc    = r_cnt + DIV_WIDTH'(1);

  // NOTE: all state below uses non-blocking assignments, so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= step_btn;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_btn_db <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_sync2 != r_btn_db) begin
      if (r_db_cnt == DB_LAST) begin
        r_btn_db <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_state       <= AUTO_LOW;
      r_cnt         <= '0;
      r_clk_out     <= 1'b0;
      r_not_clk_out <= 1'b1;
      r_clk_rise    <= 1'b0;
    end else begin
      r_clk_rise <= 1'b0;
      if (halt) begin
        // Halt cuts a high phase short rather than waiting for it to complete.
        r_state       <= HALTED;
        r_cnt         <= '0;
        r_clk_out     <= 1'b0;
        r_not_clk_out <= 1'b1;
      end else begin
        unique case (r_state)
          AUTO_LOW: begin
            if (mode) begin
              r_state <= MAN_IDLE;
              r_cnt   <= '0;
            end else if (w_phase_done) begin
              r_state       <= AUTO_HIGH;
              r_cnt         <= '0;
              r_clk_out     <= 1'b1;
              r_not_clk_out <= 1'b0;
              r_clk_rise    <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          AUTO_HIGH: begin
            if (w_phase_done) begin
              r_state       <= AUTO_LOW;
              r_cnt         <= '0;
              r_clk_out     <= 1'b0;
              r_not_clk_out <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          MAN_IDLE: begin
            r_cnt <= '0;
            if (!mode) begin
              r_state <= AUTO_LOW;
            end else if (r_btn_db) begin
              r_state       <= MAN_HIGH;
              r_clk_out     <= 1'b1;
              r_not_clk_out <= 1'b0;
              r_clk_rise    <= 1'b1;
            end
          end
          MAN_HIGH: begin
            if (w_step_done) begin
              r_state       <= MAN_WAIT_REL;
              r_cnt         <= '0;
              r_clk_out     <= 1'b0;
              r_not_clk_out <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          MAN_WAIT_REL: begin
            r_cnt <= '0;
            if (!mode) begin
              r_state <= AUTO_LOW;
            end else if (!r_btn_db) begin
              r_state <= MAN_IDLE;
            end
          end
          HALTED: begin
            r_cnt <= '0;
            if (!mode) begin
              r_state <= AUTO_LOW;
            end else if (r_btn_db) begin
              r_state <= MAN_WAIT_REL;
            end else begin
              r_state <= MAN_IDLE;
            end
          end
          default: begin
            r_state       <= AUTO_LOW;
            r_cnt         <= '0;
            r_clk_out     <= 1'b0;
            r_not_clk_out <= 1'b1;
          end
        endcase
      end
    end
  end

  assign clk_out     = r_clk_out;
  assign not_clk_out = r_not_clk_out;
  assign clk_rise    = r_clk_rise;

  property p_rise_single;
    @(posedge clk) disable iff (!not_reset) r_clk_rise |=> !r_clk_rise;
  endproperty
  a_rise_single: assert property (p_rise_single);

  property p_complement;
    @(posedge clk) disable iff (!not_reset) r_not_clk_out == ~r_clk_out;
  endproperty
  a_complement: assert property (p_complement);

endmodule

// File: tb/tb_clock_module.sv
// Testbench for clock_module. It runs table-driven auto-mode periods, directed multi-cycle
// sequences, and randomized stimulus compared against a behavioural reference model.
module tb_clock_module;

  localparam int DW = 16;
  localparam int DB = 4;
  localparam int SH = 4;

  logic          clk       = 1'b0;
  logic          not_reset = 1'b0;
  logic          mode      = 1'b0;
  logic          step_btn  = 1'b0;
  logic          halt      = 1'b0;
  logic [DW-1:0] div       = '0;
  logic          clk_out;
  logic          not_clk_out;
  logic          clk_rise;

  int total = 0;
  int bad   = 0;

  clock_module #(
    .DIV_WIDTH       (DW),
    .DEBOUNCE_CYCLES (DB),
    .STEP_HIGH_CYCLES(SH)
  ) dut (
    .clk        (clk),
    .not_reset  (not_reset),
    .mode       (mode),
    .step_btn   (step_btn),
    .halt       (halt),
    .div        (div),
    .clk_out    (clk_out),
    .not_clk_out(not_clk_out),
    .clk_rise   (clk_rise)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            exp_high;
    int            exp_low;
  } auto_vec_t;

  auto_vec_t vecs[5];

  // Reference model state: machine kind (0 auto, 1 manual, 2 halted), output level, age of the
  // current level in edges, a "waiting for release" flag, and the button pipeline with history.
  int m_kind;
  bit m_lvl;
  int m_age;
  bit m_wait;
  bit m_rise;
  bit m_deb;
  bit m_s1;
  bit m_s2;
  bit m_hist[DB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input logic m, input logic [DW-1:0] d);
    mode      = m;
    div       = d;
    halt      = 1'b0;
    step_btn  = 1'b0;
    not_reset = 1'b0;
    tick(2);
    check("reset_clk_out", clk_out, 1'b0);
    check("reset_not_clk_out", not_clk_out, 1'b1);
    check("reset_clk_rise", clk_rise, 1'b0);
    not_reset = 1'b1;
  endtask

  // Counts edges until clk_out leaves lvl; rises counts clk_rise strobes seen meanwhile.
  task automatic measure(input logic lvl, input int budget, output int n, output int rises);
    n     = 0;
    rises = 0;
    while (clk_out === lvl) begin
      if (n >= budget) begin
        n = -1;
        return;
      end
      tick(1);
      n++;
      if (clk_rise) rises++;
    end
  endtask

  task automatic quiet(input int cycles, output int highs, output int rises);
    highs = 0;
    rises = 0;
    repeat (cycles) begin
      tick(1);
      if (clk_out !== 1'b0) highs++;
      if (clk_rise !== 1'b0) rises++;
    end
  endtask

  task automatic model_reset();
    m_kind = 0;
    m_lvl  = 1'b0;
    m_age  = 0;
    m_wait = 1'b0;
    m_rise = 1'b0;
    m_deb  = 1'b0;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    for (int i = 0; i < DB; i++) m_hist[i] = 1'b0;
  endtask

  task automatic model_step();
    bit old_deb;
    bit old_s2;
    bit all_diff;
    old_deb = m_deb;
    old_s2  = m_s2;
    m_rise  = 1'b0;
    if (halt) begin
      m_kind = 2;
      m_lvl  = 1'b0;
      m_age  = 0;
    end else begin
      case (m_kind)
        0: begin
          if (!m_lvl && mode) begin
            m_kind = 1;
            m_wait = 1'b0;
            m_age  = 0;
          end else if (m_age >= int'(div)) begin
            m_lvl  = !m_lvl;
            m_rise = m_lvl;
            m_age  = 0;
          end else begin
            m_age++;
          end
        end
        1: begin
          if (m_lvl) begin
            if (m_age >= SH - 1) begin
              m_lvl  = 1'b0;
              m_wait = 1'b1;
              m_age  = 0;
            end else begin
              m_age++;
            end
          end else if (!mode) begin
            m_kind = 0;
            m_age  = 0;
          end else if (m_wait) begin
            if (!old_deb) m_wait = 1'b0;
          end else if (old_deb) begin
            m_lvl  = 1'b1;
            m_rise = 1'b1;
            m_age  = 0;
          end
        end
        default: begin
          m_age = 0;
          if (mode) begin
            m_kind = 1;
            m_wait = old_deb;
          end else begin
            m_kind = 0;
          end
        end
      endcase
    end
    // The debounced level flips once the last DB synchronised samples all disagree with it.
    for (int i = DB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = old_s2;
    all_diff  = 1'b1;
    for (int i = 0; i < DB; i++) if (m_hist[i] == m_deb) all_diff = 1'b0;
    if (all_diff) m_deb = !m_deb;
    m_s2 = m_s1;
    m_s1 = step_btn;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int r;
    int h;

    vecs[0] = '{d: 16'd0, exp_high: 1, exp_low: 1};
    vecs[1] = '{d: 16'd1, exp_high: 2, exp_low: 2};
    vecs[2] = '{d: 16'd3, exp_high: 4, exp_low: 4};
    vecs[3] = '{d: 16'd6, exp_high: 7, exp_low: 7};
    vecs[4] = '{d: 16'd9, exp_high: 10, exp_low: 10};

    // Reset release with div=2: the first rise lands on edge 3; a reset while high drops outputs at once.
    apply_reset(1'b0, 16'd2);
    tick(1);
    check("rst_edge1_low", clk_out, 1'b0);
    tick(1);
    check("rst_edge2_low", clk_out, 1'b0);
    tick(1);
    check("rst_edge3_high", clk_out, 1'b1);
    check("rst_edge3_rise", clk_rise, 1'b1);
    #2 not_reset = 1'b0;
    #1;
    check("rst_async_clk_out", clk_out, 1'b0);
    check("rst_async_not_clk_out", not_clk_out, 1'b1);
    check("rst_async_clk_rise", clk_rise, 1'b0);
    tick(1);
    not_reset = 1'b1;

    // Auto-mode phase lengths from the table.
    foreach (vecs[i]) begin
      apply_reset(1'b0, vecs[i].d);
      measure(1'b0, 100, n, r);
      check($sformatf("auto%0d_first_low", i), n, vecs[i].exp_low);
      check($sformatf("auto%0d_first_rise", i), r, 1);
      measure(1'b1, 100, n, r);
      check($sformatf("auto%0d_high", i), n, vecs[i].exp_high);
      check($sformatf("auto%0d_high_rises", i), r, 0);
      measure(1'b0, 100, n, r);
      check($sformatf("auto%0d_low", i), n, vecs[i].exp_low);
      check($sformatf("auto%0d_low_rises", i), r, 1);
    end

    // Lowering div from 10 to 2 at cnt=7 ends the phase on the next edge.
    apply_reset(1'b0, 16'd10);
    measure(1'b0, 100, n, r);
    check("divchg_first_low", n, 11);
    tick(7);
    div = 16'd2;
    tick(1);
    check("divchg_cut_short", clk_out, 1'b0);
    measure(1'b0, 100, n, r);
    check("divchg_low3", n, 3);
    measure(1'b1, 100, n, r);
    check("divchg_high3", n, 3);

    // Manual step: a bouncing press gives one 4-cycle pulse, 7 edges after the last bounce.
    apply_reset(1'b1, 16'd2);
    tick(3);
    step_btn = 1'b1;
    tick(1);
    step_btn = 1'b0;
    tick(1);
    step_btn = 1'b1;
    measure(1'b0, 100, n, r);
    check("man_press_latency", n, 7);
    check("man_press_rise", r, 1);
    measure(1'b1, 100, n, r);
    check("man_pulse_high", n, SH);
    quiet(19, h, r);
    check("man_hold_highs", h, 0);
    check("man_hold_rises", r, 0);
    step_btn = 1'b0;
    quiet(12, h, r);
    check("man_release_highs", h, 0);
    step_btn = 1'b1;
    measure(1'b0, 100, n, r);
    check("man_repress_latency", n, 7);
    measure(1'b1, 100, n, r);
    check("man_repress_high", n, SH);
    step_btn = 1'b0;
    tick(12);

    // Halt two cycles into a high phase; on release, one edge leaves HALTED, then a full 6-cycle low phase.
    apply_reset(1'b0, 16'd5);
    measure(1'b0, 100, n, r);
    check("halt_first_low", n, 6);
    tick(2);
    halt = 1'b1;
    tick(1);
    check("halt_clk_out", clk_out, 1'b0);
    check("halt_not_clk_out", not_clk_out, 1'b1);
    quiet(20, h, r);
    check("halt_hold_highs", h, 0);
    check("halt_hold_rises", r, 0);
    halt = 1'b0;
    measure(1'b0, 100, n, r);
    check("halt_release_low", n, 7);
    check("halt_release_rise", r, 1);

    // Switching to manual mid-high lets the high phase finish, then the clock waits for the button.
    apply_reset(1'b0, 16'd3);
    measure(1'b0, 100, n, r);
    tick(1);
    mode = 1'b1;
    measure(1'b1, 100, n, r);
    check("mode_high_remaining", n, 3);
    quiet(20, h, r);
    check("mode_wait_highs", h, 0);
    check("mode_wait_rises", r, 0);
    step_btn = 1'b1;
    measure(1'b0, 100, n, r);
    check("mode_press_latency", n, 7);
    measure(1'b1, 100, n, r);
    check("mode_press_high", n, SH);
    step_btn = 1'b0;
    tick(12);

    // Randomised stimulus against the reference model.
    apply_reset(1'b0, 16'd3);
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(63) == 0) mode = ~mode;
      if (halt) begin
        if ($urandom_range(7) == 0) halt = 1'b0;
      end else if ($urandom_range(99) == 0) begin
        halt = 1'b1;
      end
      if ($urandom_range(9) == 0) step_btn = ~step_btn;
      if ($urandom_range(99) == 0) div = DW'($urandom_range(5));
      @(posedge clk);
      model_step();
      #1;
      check("rnd_clk_out", clk_out, m_lvl);
      check("rnd_not_clk_out", not_clk_out, !m_lvl);
      check("rnd_clk_rise", clk_rise, m_rise);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
